// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - FIFO read-side drain controller with 2-entry output buffer
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_threshold,
    input  logic                  fifo_underflow,
    input  logic                  flush,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  err_underflow
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic [2:0]            occ_after;
    logic                  space;

    // buf0 is always the head; a read is only issued when its word is
    // guaranteed a slot, counting the word already in flight.
    assign valid         = (buf_cnt_q != 2'd0);
    assign pop           = valid & ready;
    assign occ_after     = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign space         = (occ_after < 3'd2);
    assign fifo_rd       = (state_q == S_DRAIN) & ~fifo_empty & ~hold & space;
    assign data_out      = buf0_q;
    assign busy          = (state_q == S_DRAIN) | inflight_q | valid;
    assign word_count    = word_count_q;
    assign err_underflow = err_q;

    // Next-state: drain FSM, in-flight tracking, counters and sticky error
    always_comb begin
        state_d      = state_q;
        inflight_d   = fifo_rd;
        word_count_d = word_count_q + (pop ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0);
        err_d        = err_q | fifo_underflow;
        case (state_q)
            S_IDLE:  if (~fifo_empty & (fifo_threshold | flush)) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty & ~fifo_rd)                  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next-state: 2-entry buffer, shift on pop, append returning read data at tail
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        case ({inflight_q, pop})
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end
            end
            2'b01: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf1_d = fifo_data_out;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    // State registers; reset discards buffered and in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            buf_cnt_q    <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            inflight_q   <= 1'b0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_cnt_q    <= buf_cnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - scoreboard bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_rd;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_threshold;
    logic        fifo_underflow;
    logic        flush;
    logic        hold;
    logic [7:0]  data_out;
    logic        valid;
    logic        ready;
    logic        busy;
    logic [15:0] word_count;
    logic        err_underflow;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          pop_cnt = 0;
    int          cyc = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    int          max_occ = 0;
    int          thr_level = 16;
    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];

    fifo_drain_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_rd        (fifo_rd),
        .fifo_data_out  (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_underflow (fifo_underflow),
        .flush          (flush),
        .hold           (hold),
        .data_out       (data_out),
        .valid          (valid),
        .ready          (ready),
        .busy           (busy),
        .word_count     (word_count),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic void upd_flags();
        fifo_empty     = (fq.size() == 0);
        fifo_threshold = (fq.size() >= thr_level);
    endfunction

    // FIFO model: registered read data, one cycle after fifo_rd
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_dout <= 8'h00;
            upd_flags();
        end else if (fifo_rd) begin
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
            upd_flags();
        end
    end

    // Monitor: sample mid-cycle, compare each accepted word with the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (fifo_rd) rd_cnt++;
            if (valid && ready) begin
                pop_cnt++;
                if (pop_cnt == 1) first_pop = cyc;
                last_pop = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %02h, none expected", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        n_fail++;
                        $display("FAIL data_order: got %02h, expected %02h", data_out, e);
                    end
                end
            end
            if (rd_cnt - pop_cnt > max_occ) max_occ = rd_cnt - pop_cnt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        upd_flags();
    endtask

    task automatic fill(input int n);
        for (int i = 1; i <= n; i++) push(8'(i));
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        flush = 1'b0;
        hold = 1'b0;
        fifo_underflow = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rd_cnt = 0;
        pop_cnt = 0;
        max_occ = 0;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_idle(input string name, input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy && fifo_empty && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            ready = toggle ? ~ready : 1'b1;
            step(1);
        end
        check({name, "_idle_timeout"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        flush = 1'b0;
        hold = 1'b0;
        fifo_underflow = 1'b0;
        upd_flags();
        #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);
        check("rst_err", {31'd0, err_underflow}, 32'd0);
        do_reset();

        // 1: threshold-triggered drain of 16 bytes
        thr_level = 16;
        ready = 1'b1;
        fill(16);
        wait_idle("t1", 1'b0);
        check("t1_word_count", {16'd0, word_count}, 32'd16);
        check("t1_rd_pulses", rd_cnt, 32'd16);
        check("t1_back_to_back", last_pop - first_pop, 32'd15);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2: backpressure stops reads after two
        do_reset();
        thr_level = 100;
        fill(8);
        flush_pulse();
        step(10);
        check("t2_rd_pulses", rd_cnt, 32'd2);
        check("t2_valid", {31'd0, valid}, 32'd1);
        check("t2_data_head", {24'd0, data_out}, 32'h01);
        wait_idle("t2", 1'b0);
        check("t2_word_count", {16'd0, word_count}, 32'd8);

        // 3: flush below threshold
        do_reset();
        ready = 1'b1;
        fill(3);
        flush_pulse();
        wait_idle("t3", 1'b0);
        check("t3_word_count", {16'd0, word_count}, 32'd3);
        check("t3_busy", {31'd0, busy}, 32'd0);

        // 4: toggling ready, 17 bytes
        do_reset();
        fill(17);
        flush_pulse();
        wait_idle("t4", 1'b1);
        check("t4_word_count", {16'd0, word_count}, 32'd17);
        check("t4_occ_le_2", {31'd0, max_occ <= 2}, 32'd1);

        // 5: asynchronous reset mid-drain
        do_reset();
        ready = 1'b1;
        fill(16);
        flush_pulse();
        for (int i = 0; i < 100 && pop_cnt < 5; i++) step(1);
        check("t5_reached_5", {31'd0, pop_cnt >= 5}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", {31'd0, valid}, 32'd0);
        check("t5_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_word_count", {16'd0, word_count}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(10);
        check("t5_no_output", {31'd0, valid}, 32'd0);
        check("t5_wc_after", {16'd0, word_count}, 32'd0);

        // 6: sticky underflow error and hold
        do_reset();
        fifo_underflow = 1'b1;
        step(1);
        fifo_underflow = 1'b0;
        check("t6_err_set", {31'd0, err_underflow}, 32'd1);
        step(5);
        check("t6_err_sticky", {31'd0, err_underflow}, 32'd1);
        ready = 1'b1;
        fill(10);
        flush_pulse();
        step(3);
        hold = 1'b1;
        step(1);
        begin
            int r0;
            r0 = rd_cnt;
            step(6);
            check("t6_hold_no_rd", rd_cnt, r0);
        end
        check("t6_hold_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        hold = 1'b0;
        wait_idle("t6", 1'b0);
        check("t6_word_count", {16'd0, word_count}, 32'd10);
        check("t6_err_still", {31'd0, err_underflow}, 32'd1);
        do_reset();
        check("t6_err_cleared", {31'd0, err_underflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
